datapath_regfile: RTL and testbench
===================================

// Module: datapath_regfile
// PURPOSE
// - Register file and status-flag stage directly upstream of the function unit (FU) in the mycpu datapath.
// - Supplies the FU operands a_out/b_out, with a constant-insertion mux on the B path.
// - Captures the write-back word selected from FU result or memory data, plus the FU Z/N flags, on clk.
// - Single-issue: one write and two combinational reads per cycle.
// PARAMETERS
// - DATA_W  16  register/data width; must match the FU operand width
// - ADDR_W  3   register address width; depth = 2**ADDR_W (8 registers R0..R7)
// PORTS
// - clk          in   1       system clock, rising edge
// - rst          in   1       synchronous, active-high reset
// - rw           in   1       register write enable for this cycle
// - da           in   ADDR_W  destination register address
// - aa           in   ADDR_W  A read address
// - ba           in   ADDR_W  B read address
// - md_sel       in   1       write-back source: 0 = fu_f_in, 1 = mem_data_in
// - fu_f_in      in   DATA_W  FU result (FU f_out)
// - mem_data_in  in   DATA_W  data-memory read word
// - mb_sel       in   1       B operand source: 0 = register[ba], 1 = const_in
// - const_in     in   DATA_W  zero-extended instruction constant
// - flag_we      in   1       load Z/N status flags this cycle
// - fu_z_in      in   1       FU z_out
// - fu_n_in      in   1       FU n_out
// - a_out        out  DATA_W  A operand to FU a_in; also the memory address
// - b_out        out  DATA_W  B operand to FU b_in, after the mb_sel mux
// - mem_data_out out  DATA_W  register[ba] before the mb_sel mux; memory write data
// - z_flag       out  1       registered zero flag
// - n_flag       out  1       registered negative flag
// BEHAVIOUR
// - Storage: 2**ADDR_W x DATA_W flip-flop array. R0 is an ordinary writable register.
// - Reset: on a rising clk edge with rst=1, all registers are cleared to 0 and z_flag/n_flag are cleared to 0.
//   - Reset has priority over rw and flag_we asserted in the same cycle; no write occurs.
//   - During and after reset, a_out, b_out and mem_data_out read 0 unless mb_sel=1 or bypass applies.
// - Write-back data: wb = md_sel ? mem_data_in : fu_f_in.
//   - On a clk edge with rw=1 and rst=0, register[da] <= wb.
//   - With rw=0, da, md_sel and the wb sources are don't-care.
// - Reads are combinational, with zero-cycle latency from aa/ba:
//   - a_out = register[aa]
//   - mem_data_out = register[ba]
//   - b_out = mb_sel ? const_in : mem_data_out
// - Write-read ordering without bypass: a write becomes visible to reads on the cycle after the edge that commits it.
// - aa == ba is legal; both ports return the same register.
// - Flags: on a clk edge with flag_we=1 and rst=0, z_flag <= fu_z_in and n_flag <= fu_n_in. With flag_we=0 the flags hold.
// - Flags are independent of rw; a flag-only update (compare) is legal.
// - Widths: every path is exactly DATA_W bits, with no extension or truncation. const_in arrives already zero-extended.
// - Addresses cannot go out of range, because the depth is exactly 2**ADDR_W.
// CONFIGURATION
// - Macro REGFILE_BYPASS_EN.
// - Defined: when rw=1 and aa==da, a_out = wb combinationally in the same cycle. Likewise mem_data_out/b_out for ba==da.
//   - mb_sel=1 still forces const_in onto b_out.
//   - Bypass is suppressed while rst=1.
// - Undefined: no forwarding. Reads always return the stored array contents.
// - A caller must not build a combinational loop by routing FU output back to a_in through the bypass in the same cycle.
//   - The mycpu top level drives the FU from a_out/b_out, so REGFILE_BYPASS_EN is used only with a pipeline register on fu_f_in.
// TESTING
// - Reset: rst=1 for 2 cycles with rw=1, da=3, fu_f_in=16'hBEEF -> after release, every aa read returns 16'h0000 and z_flag=n_flag=0.
// - Write/read: rw=1, da=5, md_sel=0, fu_f_in=16'h1234, then aa=5 -> a_out=16'h1234 on the next cycle. md_sel=1, mem_data_in=16'h00A5, da=2 -> R2=16'h00A5.
// - Same-cycle read of the write target: aa=da=4, rw=1, fu_f_in=16'h5555, R4 previously 16'h0007
//   - bypass undefined: a_out=16'h0007 this cycle, 16'h5555 next cycle
//   - REGFILE_BYPASS_EN defined: a_out=16'h5555 in the same cycle
// - B mux: R6=16'h00FF, ba=6. mb_sel=1 with const_in=16'h0003 -> b_out=16'h0003 and mem_data_out=16'h00FF. mb_sel=0 -> b_out=16'h00FF.
// - Flags: flag_we=1, fu_z_in=1, fu_n_in=0 -> z_flag=1, n_flag=0 next cycle. Then flag_we=0 with fu_z_in=0, fu_n_in=1 -> flags hold at 1/0.
// - Reset mid-operation: R1=16'hAAAA and z_flag=1, then a cycle with rst=1, rw=1, da=1, flag_we=1 -> R1=16'h0000 and z_flag=0 afterwards.

Source files
------------

// File: rtl/datapath_regfile.sv
// datapath_regfile: 2**ADDR_W x DATA_W register file with Z/N status flags,
// feeding the FU operand ports (A direct, B through a constant-insertion mux).
// Optional build macro REGFILE_BYPASS_EN: same-cycle write-to-read forwarding.
module datapath_regfile #(
    parameter int unsigned DATA_W = 16,
    parameter int unsigned ADDR_W = 3
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              rw,
    input  logic [ADDR_W-1:0] da,
    input  logic [ADDR_W-1:0] aa,
    input  logic [ADDR_W-1:0] ba,
    input  logic              md_sel,
    input  logic [DATA_W-1:0] fu_f_in,
    input  logic [DATA_W-1:0] mem_data_in,
    input  logic              mb_sel,
    input  logic [DATA_W-1:0] const_in,
    input  logic              flag_we,
    input  logic              fu_z_in,
    input  logic              fu_n_in,
    output logic [DATA_W-1:0] a_out,
    output logic [DATA_W-1:0] b_out,
    output logic [DATA_W-1:0] mem_data_out,
    output logic              z_flag,
    output logic              n_flag
);

    localparam int unsigned DEPTH = 2 ** ADDR_W;

    logic [DATA_W-1:0] regs [DEPTH];
    logic [DATA_W-1:0] wb;
    logic [DATA_W-1:0] a_rd;
    logic [DATA_W-1:0] b_rd;

    // Write-back source select: FU result or memory read word.
    always_comb begin
        wb = md_sel ? mem_data_in : fu_f_in;
    end

    // Register array: synchronous clear on reset, single write port otherwise.
    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < int'(DEPTH); i++) begin
                regs[i] <= '0;
            end
        end else if (rw) begin
            regs[da] <= wb;
        end
    end

    // Status flags: loaded only on flag_we, independent of register writes.
    always_ff @(posedge clk) begin
        if (rst) begin
            z_flag <= 1'b0;
            n_flag <= 1'b0;
        end else if (flag_we) begin
            z_flag <= fu_z_in;
            n_flag <= fu_n_in;
        end
    end

    // Combinational read ports; optional forwarding of the pending write.
    always_comb begin
        a_rd = regs[aa];
        b_rd = regs[ba];
`ifdef REGFILE_BYPASS_EN
        if (!rst && rw && (aa == da)) begin
            a_rd = wb;
        end
        if (!rst && rw && (ba == da)) begin
            b_rd = wb;
        end
`endif
    end

    // Operand outputs; constant insertion applies to the B operand only.
    always_comb begin
        a_out        = a_rd;
        mem_data_out = b_rd;
        b_out        = mb_sel ? const_in : b_rd;
    end

endmodule

// File: tb/tb_datapath_regfile.sv
// Directed self-checking bench for datapath_regfile.
module tb_datapath_regfile;

    logic        clk = 1'b0;
    logic        rst;
    logic        rw;
    logic [2:0]  da;
    logic [2:0]  aa;
    logic [2:0]  ba;
    logic        md_sel;
    logic [15:0] fu_f_in;
    logic [15:0] mem_data_in;
    logic        mb_sel;
    logic [15:0] const_in;
    logic        flag_we;
    logic        fu_z_in;
    logic        fu_n_in;
    logic [15:0] a_out;
    logic [15:0] b_out;
    logic [15:0] mem_data_out;
    logic        z_flag;
    logic        n_flag;

    int errors = 0;
    int checks = 0;

    datapath_regfile #(.DATA_W(16), .ADDR_W(3)) dut (
        .clk         (clk),
        .rst         (rst),
        .rw          (rw),
        .da          (da),
        .aa          (aa),
        .ba          (ba),
        .md_sel      (md_sel),
        .fu_f_in     (fu_f_in),
        .mem_data_in (mem_data_in),
        .mb_sel      (mb_sel),
        .const_in    (const_in),
        .flag_we     (flag_we),
        .fu_z_in     (fu_z_in),
        .fu_n_in     (fu_n_in),
        .a_out       (a_out),
        .b_out       (b_out),
        .mem_data_out(mem_data_out),
        .z_flag      (z_flag),
        .n_flag      (n_flag)
    );

    always #5 clk = ~clk;

    // Advance past one rising edge; inputs change and outputs are sampled 1ns later.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic write_reg(input logic [2:0] addr, input logic [15:0] val);
        rw = 1'b1; da = addr; md_sel = 1'b0; fu_f_in = val;
        tick();
        rw = 1'b0;
    endtask

    task automatic test_reset();
        rst = 1'b1; rw = 1'b1; da = 3'd3; fu_f_in = 16'hBEEF; md_sel = 1'b0;
        flag_we = 1'b1; fu_z_in = 1'b1; fu_n_in = 1'b1;
        tick();
        tick();
        rst = 1'b0; rw = 1'b0; flag_we = 1'b0; mb_sel = 1'b0;
        for (int i = 0; i < 8; i++) begin
            aa = 3'(i);
            ba = 3'(i);
            #1;
            checks++;
            if (a_out !== 16'h0000) begin
                errors++;
                $display("FAIL reset_a R%0d: got %h want 0000", i, a_out);
            end
            checks++;
            if (mem_data_out !== 16'h0000) begin
                errors++;
                $display("FAIL reset_md R%0d: got %h want 0000", i, mem_data_out);
            end
        end
        checks++;
        if (z_flag !== 1'b0 || n_flag !== 1'b0) begin
            errors++;
            $display("FAIL reset_flags: got z=%b n=%b want 0/0", z_flag, n_flag);
        end
    endtask

    task automatic test_write_read();
        rw = 1'b1; da = 3'd5; md_sel = 1'b0; fu_f_in = 16'h1234; mem_data_in = 16'hFFFF;
        tick();
        rw = 1'b0; aa = 3'd5;
        #1;
        checks++;
        if (a_out !== 16'h1234) begin
            errors++;
            $display("FAIL wr_fu: got %h want 1234", a_out);
        end
        rw = 1'b1; da = 3'd2; md_sel = 1'b1; mem_data_in = 16'h00A5; fu_f_in = 16'hFFFF;
        tick();
        rw = 1'b0; aa = 3'd2; ba = 3'd5; mb_sel = 1'b0;
        #1;
        checks++;
        if (a_out !== 16'h00A5) begin
            errors++;
            $display("FAIL wr_mem: got %h want 00a5", a_out);
        end
        checks++;
        if (mem_data_out !== 16'h1234) begin
            errors++;
            $display("FAIL rd_b_r5: got %h want 1234", mem_data_out);
        end
    endtask

    task automatic test_same_cycle();
        logic [15:0] exp_now;
        write_reg(3'd4, 16'h0007);
`ifdef REGFILE_BYPASS_EN
        exp_now = 16'h5555;
`else
        exp_now = 16'h0007;
`endif
        aa = 3'd4; ba = 3'd4; mb_sel = 1'b0;
        rw = 1'b1; da = 3'd4; md_sel = 1'b0; fu_f_in = 16'h5555;
        #1;
        checks++;
        if (a_out !== exp_now) begin
            errors++;
            $display("FAIL same_cycle_a: got %h want %h", a_out, exp_now);
        end
        checks++;
        if (b_out !== exp_now) begin
            errors++;
            $display("FAIL same_cycle_b: got %h want %h", b_out, exp_now);
        end
        tick();
        rw = 1'b0;
        #1;
        checks++;
        if (a_out !== 16'h5555) begin
            errors++;
            $display("FAIL next_cycle_a: got %h want 5555", a_out);
        end
    endtask

    task automatic test_b_mux();
        write_reg(3'd6, 16'h00FF);
        ba = 3'd6; aa = 3'd6; mb_sel = 1'b1; const_in = 16'h0003;
        #1;
        checks++;
        if (b_out !== 16'h0003) begin
            errors++;
            $display("FAIL bmux_const: got %h want 0003", b_out);
        end
        checks++;
        if (mem_data_out !== 16'h00FF) begin
            errors++;
            $display("FAIL bmux_memdata: got %h want 00ff", mem_data_out);
        end
        checks++;
        if (a_out !== 16'h00FF) begin
            errors++;
            $display("FAIL aa_eq_ba: got %h want 00ff", a_out);
        end
        mb_sel = 1'b0;
        #1;
        checks++;
        if (b_out !== 16'h00FF) begin
            errors++;
            $display("FAIL bmux_reg: got %h want 00ff", b_out);
        end
    endtask

    task automatic test_flags();
        rw = 1'b0; flag_we = 1'b1; fu_z_in = 1'b1; fu_n_in = 1'b0;
        tick();
        checks++;
        if (z_flag !== 1'b1 || n_flag !== 1'b0) begin
            errors++;
            $display("FAIL flags_load: got z=%b n=%b want 1/0", z_flag, n_flag);
        end
        flag_we = 1'b0; fu_z_in = 1'b0; fu_n_in = 1'b1;
        tick();
        checks++;
        if (z_flag !== 1'b1 || n_flag !== 1'b0) begin
            errors++;
            $display("FAIL flags_hold: got z=%b n=%b want 1/0", z_flag, n_flag);
        end
        flag_we = 1'b1;
        tick();
        flag_we = 1'b0;
        checks++;
        if (z_flag !== 1'b0 || n_flag !== 1'b1) begin
            errors++;
            $display("FAIL flags_compare: got z=%b n=%b want 0/1", z_flag, n_flag);
        end
    endtask

    task automatic test_reset_mid();
        rw = 1'b1; da = 3'd1; md_sel = 1'b0; fu_f_in = 16'hAAAA;
        flag_we = 1'b1; fu_z_in = 1'b1; fu_n_in = 1'b0;
        tick();
        rw = 1'b0; flag_we = 1'b0; aa = 3'd1;
        #1;
        checks++;
        if (a_out !== 16'hAAAA || z_flag !== 1'b1) begin
            errors++;
            $display("FAIL mid_setup: got %h z=%b want aaaa z=1", a_out, z_flag);
        end
        rst = 1'b1; rw = 1'b1; da = 3'd1; fu_f_in = 16'h1111;
        flag_we = 1'b1; fu_z_in = 1'b1; fu_n_in = 1'b1;
        #1;
        checks++;
        if (a_out !== 16'hAAAA) begin
            errors++;
            $display("FAIL rst_no_bypass: got %h want aaaa", a_out);
        end
        tick();
        rst = 1'b0; rw = 1'b0; flag_we = 1'b0;
        #1;
        checks++;
        if (a_out !== 16'h0000) begin
            errors++;
            $display("FAIL mid_reset_r1: got %h want 0000", a_out);
        end
        checks++;
        if (z_flag !== 1'b0 || n_flag !== 1'b0) begin
            errors++;
            $display("FAIL mid_reset_flags: got z=%b n=%b want 0/0", z_flag, n_flag);
        end
    endtask

    task automatic test_back_to_back();
        logic [15:0] vals [8];
        vals = '{16'h8001, 16'h0102, 16'h2203, 16'h3304,
                 16'h4405, 16'hFFFF, 16'h6607, 16'h7708};
        for (int i = 0; i < 8; i++) begin
            write_reg(3'(i), vals[i]);
            rw = 1'b0;
        end
        mb_sel = 1'b0;
        for (int i = 0; i < 8; i++) begin
            aa = 3'(i);
            ba = 3'(7 - i);
            #1;
            checks++;
            if (a_out !== vals[i] || b_out !== vals[7 - i]) begin
                errors++;
                $display("FAIL b2b R%0d: got a=%h b=%h want a=%h b=%h",
                         i, a_out, b_out, vals[i], vals[7 - i]);
            end
        end
    endtask

    initial begin
        rst = 1'b1; rw = 1'b0; da = '0; aa = '0; ba = '0; md_sel = 1'b0;
        fu_f_in = '0; mem_data_in = '0; mb_sel = 1'b0; const_in = '0;
        flag_we = 1'b0; fu_z_in = 1'b0; fu_n_in = 1'b0;
        test_reset();
        test_write_read();
        test_same_cycle();
        test_b_mux();
        test_flags();
        test_reset_mid();
        test_back_to_back();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
